// File: rtl/cpu_mem_pkg.sv
// Shared widths, arbiter state encoding and the round-robin pick helper.
// Latency: none, this file holds declarations only; backpressure: n/a.
package cpu_mem_pkg;

  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 16;

  typedef logic [1:0] arb_state_t;

  localparam arb_state_t ST_IDLE    = 2'd0;
  localparam arb_state_t ST_GNT_CPU = 2'd1;
  localparam arb_state_t ST_GNT_VGA = 2'd2;

  // A tie can only occur in IDLE, so last_vga alone decides the winner.
  function automatic arb_state_t rr_pick(input logic cpu_ok, input logic vga_ok,
                                         input logic last_vga);
    if (cpu_ok && vga_ok) return last_vga ? ST_GNT_CPU : ST_GNT_VGA;
    if (cpu_ok)           return ST_GNT_CPU;
    if (vga_ok)           return ST_GNT_VGA;
    return ST_IDLE;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// CPU, display-fetch and single-port RAM signals shared by the arbiter and its users.
// Latency: none, wiring only; backpressure: each req is held until the matching gnt.
interface mem_port_arbiter_if
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) ();

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;

  logic              vga_req;
  logic [ADDR_W-1:0] vga_addr;
  logic              vga_gnt;
  logic              vga_rvalid;
  logic [DATA_W-1:0] vga_rdata;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // Requesters plus the RAM model.
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, vga_req, vga_addr, mem_rdata,
    input  cpu_gnt, cpu_rvalid, cpu_rdata, vga_gnt, vga_rvalid, vga_rdata,
    input  mem_we, mem_addr, mem_wdata
  );

  // The arbiter.
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, vga_req, vga_addr, mem_rdata,
    output cpu_gnt, cpu_rvalid, cpu_rdata, vga_gnt, vga_rvalid, vga_rdata,
    output mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter, only compiled when MEM_ARB_STATS_EN is defined.
// Latency: count visible one cycle after inc; backpressure: none, sticks at all-ones.
`ifdef MEM_ARB_STATS_EN
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule
`endif

// File: rtl/mem_port_arbiter.sv
// Round-robin CPU/display arbiter for one single-port RAM; MEM_ARB_STATS_EN adds conflict_cnt.
// Latency: gnt and mem_* one cycle after req is sampled, rvalid one cycle later; backpressure: req held until gnt.
module mem_port_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  mem_port_arbiter_if.slave   bus,
  output logic [15:0]         conflict_cnt
);

  arb_state_t        state_q;
  arb_state_t        state_d;
  logic              last_vga_q;
  logic              cpu_ok;
  logic              vga_ok;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              cpu_rv_q;
  logic              vga_rv_q;
  logic [DATA_W-1:0] cpu_rd_q;
  logic [DATA_W-1:0] vga_rd_q;

  // A requester being served this cycle cannot win again until next cycle.
  assign cpu_ok  = bus.cpu_req && (state_q != ST_GNT_CPU);
  assign vga_ok  = bus.vga_req && (state_q != ST_GNT_VGA);
  assign state_d = rr_pick(cpu_ok, vga_ok, last_vga_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      last_vga_q  <= 1'b1;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_rv_q    <= 1'b0;
      vga_rv_q    <= 1'b0;
      cpu_rd_q    <= '0;
      vga_rd_q    <= '0;
    end else begin
      state_q  <= state_d;
      mem_we_q <= 1'b0;
      cpu_rv_q <= (state_q == ST_GNT_CPU) && !mem_we_q;
      vga_rv_q <= (state_q == ST_GNT_VGA);
      if (cpu_rv_q) cpu_rd_q <= bus.mem_rdata;
      if (vga_rv_q) vga_rd_q <= bus.mem_rdata;
      // Capture the winner's request so it may change right after sampling.
      case (state_d)
        ST_GNT_CPU: begin
          last_vga_q  <= 1'b0;
          mem_we_q    <= bus.cpu_we;
          mem_addr_q  <= bus.cpu_addr;
          mem_wdata_q <= bus.cpu_wdata;
        end
        ST_GNT_VGA: begin
          last_vga_q <= 1'b1;
          mem_addr_q <= bus.vga_addr;
        end
        default: ;
      endcase
    end
  end

  assign bus.cpu_gnt    = (state_q == ST_GNT_CPU);
  assign bus.vga_gnt    = (state_q == ST_GNT_VGA);
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.cpu_rvalid = cpu_rv_q;
  assign bus.vga_rvalid = vga_rv_q;
  // RAM data arrives in the rvalid cycle; the register keeps it afterwards.
  assign bus.cpu_rdata  = cpu_rv_q ? bus.mem_rdata : cpu_rd_q;
  assign bus.vga_rdata  = vga_rv_q ? bus.mem_rdata : vga_rd_q;

`ifdef MEM_ARB_STATS_EN
  // Contention means both requesters asking in the same sampled cycle.
  sat_counter #(.W(16)) u_conflict_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (bus.cpu_req && bus.vga_req),
    .cnt   (conflict_cnt)
  );
`else
  assign conflict_cnt = '0;
`endif

endmodule
